// File: rtl/yin_frame_sched.sv
// YIN front-end sequencer: writes samples into a circular RAM and, once per hop,
// walks every (tau, j) pair of an analysis frame out to the difference accumulator.
module yin_frame_sched #(
  parameter int SIG_WIDTH   = 9,
  parameter int SAMPLE_RATE = 8000,
  parameter int WINDOW_SIZE = 500,
  parameter int F_MIN       = 100,
  parameter int F_MAX       = 1000,
  parameter int HOP_SIZE    = 100,
  localparam int TAU_MAX    = SAMPLE_RATE / F_MIN,
  localparam int AW         = $clog2(WINDOW_SIZE),
  localparam int TW         = $clog2(TAU_MAX + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [SIG_WIDTH-1:0] sig_in,
  input  logic                 sig_in_valid,
  output logic                 buf_we,
  output logic [AW-1:0]        buf_waddr,
  output logic [SIG_WIDTH-1:0] buf_wdata,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [AW-1:0]        rd_addr_a,
  output logic [AW-1:0]        rd_addr_b,
  output logic [TW-1:0]        rd_tau,
  output logic                 rd_first,
  output logic                 rd_last,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TAU_MIN = SAMPLE_RATE / F_MAX;
  localparam int INT_LEN = WINDOW_SIZE - TAU_MAX;
  localparam int JW      = $clog2(INT_LEN);
  localparam int FW      = $clog2(WINDOW_SIZE + 1);
  localparam int HW      = $clog2(HOP_SIZE + 1);
  localparam int SW      = AW + 1;

  localparam logic [AW-1:0] PTR_LAST  = AW'(WINDOW_SIZE - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WINDOW_SIZE);
  localparam logic [HW-1:0] HOP_FULL  = HW'(HOP_SIZE);
  localparam logic [JW-1:0] J_LAST    = JW'(INT_LEN - 1);
  localparam logic [TW-1:0] T_MIN     = TW'(TAU_MIN);
  localparam logic [TW-1:0] T_MAX     = TW'(TAU_MAX);
  localparam logic [SW-1:0] WIN       = SW'(WINDOW_SIZE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr, wr_ptr_inc, base;
  logic [FW-1:0]  fill, fill_nxt;
  logic [HW-1:0]  hop_cnt, hop_nxt;
  logic [TW-1:0]  tau;
  logic [JW-1:0]  j;
  logic [SW-1:0]  sum_a, sum_b;
  logic           trig, launch, start_q, hs, pair_last;

  // Trigger looks at the fill/hop values as they will be after this sample.
  always_comb begin
    wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    fill_nxt   = (fill == FILL_FULL) ? fill : fill + 1'b1;
    hop_nxt    = (fill == FILL_FULL) ? hop_cnt + 1'b1 : hop_cnt;
    trig       = sig_in_valid && (fill_nxt == FILL_FULL) &&
                 ((fill != FILL_FULL) || (hop_nxt == HOP_FULL));
    launch     = trig && (state_q == S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      hop_cnt   <= '0;
      overrun   <= 1'b0;
      base      <= '0;
    end else begin
      buf_we  <= sig_in_valid;
      overrun <= trig && busy;
      if (sig_in_valid) begin
        buf_waddr <= wr_ptr;
        buf_wdata <= sig_in;
        wr_ptr    <= wr_ptr_inc;
        fill      <= fill_nxt;
        hop_cnt   <= trig ? '0 : hop_nxt;
      end
      if (launch) base <= wr_ptr_inc;
    end
  end

  assign hs        = rd_valid && rd_ready;
  assign pair_last = (tau == T_MAX) && (j == J_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN:   if (hs && pair_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lag/offset walk; counters hold during stalls so the request stays stable.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tau     <= '0;
      j       <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= launch;
      if (launch) begin
        tau <= T_MIN;
        j   <= '0;
      end else if (hs && !pair_last) begin
        if (j == J_LAST) begin
          j   <= '0;
          tau <= tau + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  // Both sums stay below 2*WINDOW_SIZE, so one conditional subtract wraps them.
  always_comb begin
    sum_a = {1'b0, base} + SW'(j);
    sum_b = sum_a + SW'(tau);
  end

  always_comb begin
    rd_valid    = (state_q == S_RUN);
    frame_done  = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
    frame_start = start_q;
    rd_first    = rd_valid && (j == '0);
    rd_last     = rd_valid && (j == J_LAST);
    rd_tau      = rd_valid ? tau : '0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    if (rd_valid) begin
      rd_addr_a = (sum_a >= WIN) ? AW'(sum_a - WIN) : AW'(sum_a);
      rd_addr_b = (sum_b >= WIN) ? AW'(sum_b - WIN) : AW'(sum_b);
    end
  end

endmodule

// File: tb/tb_yin_frame_sched.sv
// Randomized bench for yin_frame_sched against a sample-count / pair-index reference model.
module tb_yin_frame_sched;
  localparam int W     = 500;
  localparam int TMIN  = 8;
  localparam int IL    = 420;
  localparam int TOTAL = 30660;
  localparam int HOP   = 100;

  logic       clk_in = 1'b0;
  logic       rst_in, sig_in_valid, rd_ready;
  logic [8:0] sig_in, buf_waddr, buf_wdata, rd_addr_a, rd_addr_b;
  logic [6:0] rd_tau;
  logic       buf_we, rd_valid, rd_first, rd_last, frame_start, frame_done, busy, overrun;

  yin_frame_sched dut (
    .clk_in(clk_in), .rst_in(rst_in), .sig_in(sig_in), .sig_in_valid(sig_in_valid),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_tau(rd_tau), .rd_first(rd_first), .rd_last(rd_last), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  int total = 0, bad = 0;
  int rdy_mode = 0;
  int done_cnt = 0, start_cnt = 0, ov_cnt = 0, dut_hs = 0;

  // reference model state
  int m_n = 0, m_hop = 0, m_left = 0, m_base = 0, m_frames = 0, m_fidx = 0;
  int m_wa = 0, m_wd = 0;
  bit m_start = 0, m_done = 0, m_ov = 0, m_we = 0;

  int lit_fa[3] = '{0, 100, 200};
  int lit_fb[3] = '{8, 108, 208};
  int lit_la[2] = '{419, 19};
  int lit_lb[2] = '{499, 99};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    int kk, tj, tt, ea, eb;
    bit ev, nb, fire;
    if (frame_done) done_cnt++;
    if (frame_start) begin start_cnt++; dut_hs = 0; end
    if (overrun) ov_cnt++;
    if (rd_valid && rd_ready) dut_hs++;
    if (rst_in) begin
      m_n = 0; m_hop = 0; m_left = 0;
      m_start = 0; m_done = 0; m_ov = 0; m_we = 0;
    end else begin
      ev = (m_left > 0);
      chk("rd_valid", rd_valid, ev);
      chk("busy", busy, ev || m_done);
      chk("frame_start", frame_start, m_start);
      chk("frame_done", frame_done, m_done);
      chk("overrun", overrun, m_ov);
      chk("buf_we", buf_we, m_we);
      if (m_we) begin
        chk("buf_waddr", buf_waddr, m_wa);
        chk("buf_wdata", buf_wdata, m_wd);
      end
      if (frame_done) chk("hs_count", dut_hs, TOTAL);
      if (ev) begin
        kk = TOTAL - m_left;
        tt = TMIN + kk / IL;
        tj = kk % IL;
        ea = (m_base + tj) % W;
        eb = (m_base + tj + tt) % W;
        chk("rd_tau", rd_tau, tt);
        chk("rd_addr_a", rd_addr_a, ea);
        chk("rd_addr_b", rd_addr_b, eb);
        chk("rd_first", rd_first, tj == 0);
        chk("rd_last", rd_last, tj == IL - 1);
        if (m_start && m_fidx < 3) begin
          chk("lit_first_a", rd_addr_a, lit_fa[m_fidx]);
          chk("lit_first_b", rd_addr_b, lit_fb[m_fidx]);
          chk("lit_first_tau", rd_tau, 8);
          chk("lit_first_flag", rd_first, 1);
        end
        if (m_left == 1 && rd_ready && m_fidx < 2) begin
          chk("lit_last_a", rd_addr_a, lit_la[m_fidx]);
          chk("lit_last_b", rd_addr_b, lit_lb[m_fidx]);
          chk("lit_last_tau", rd_tau, 80);
          chk("lit_last_flag", rd_last, 1);
        end
      end
      nb = ev || m_done;
      m_start = 0; m_done = 0; m_ov = 0; m_we = 0;
      if (ev && rd_ready) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end
      if (sig_in_valid) begin
        m_we = 1; m_wa = m_n % W; m_wd = sig_in;
        m_n++;
        fire = 0;
        if (m_n == W) fire = 1;
        else if (m_n > W) begin
          m_hop++;
          if (m_hop == HOP) fire = 1;
        end
        if (fire) begin
          m_hop = 0;
          if (nb) m_ov = 1;
          else begin
            m_base = m_n % W; m_left = TOTAL; m_start = 1;
            m_fidx = m_frames; m_frames++;
          end
        end
      end
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ($urandom_range(3) != 0);
        default: rd_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
      sig_in_valid = 1'b1;
      sig_in = 9'($urandom);
      @(posedge clk_in); #1;
      sig_in_valid = 1'b0;
      repeat ($urandom_range(maxgap)) @(posedge clk_in);
    end
  endtask

  task automatic wait_done(input int budget);
    int d0, c;
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk_in);
      c++;
    end
    if (done_cnt == d0) begin
      total++; bad++;
      $display("FAIL frame_done_timeout: got none expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    int ov0, d0;
    rst_in = 1'b1; sig_in = '0; sig_in_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); #1;
    chk("rst_buf_we", buf_we, 0);       chk("rst_buf_waddr", buf_waddr, 0);
    chk("rst_buf_wdata", buf_wdata, 0); chk("rst_rd_valid", rd_valid, 0);
    chk("rst_addr_a", rd_addr_a, 0);    chk("rst_addr_b", rd_addr_b, 0);
    chk("rst_tau", rd_tau, 0);          chk("rst_first", rd_first, 0);
    chk("rst_last", rd_last, 0);        chk("rst_fstart", frame_start, 0);
    chk("rst_fdone", frame_done, 0);    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    send(499, 1);
    repeat (3) @(posedge clk_in);
    chk("no_early_start", start_cnt, 0);
    send(1, 0);
    wait_done(32000);
    repeat (3) @(posedge clk_in);

    rdy_mode = 1;
    send(100, 1);
    send(50, 1);
    wait_done(60000);
    repeat (3) @(posedge clk_in);

    rdy_mode = 2;
    send(50, 1);
    repeat (5) @(posedge clk_in);
    ov0 = ov_cnt;
    send(100, 1);
    repeat (3) @(posedge clk_in); #2;
    chk("overrun_once", ov_cnt - ov0, 1);
    chk("stalled_hs", dut_hs, 0);
    chk("still_busy", busy, 1);

    d0 = done_cnt;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", frame_done, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (5) @(posedge clk_in);
    chk("no_done_after_rst", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
